execute_mdu: RTL and testbench

Parametrised multiply/divide unit for the EXECUTE stage, the multi-cycle successor to the single-cycle ALU path. It runs signed and unsigned MULT/DIV with a radix-2 iterative datapath, holds the HI/LO architectural registers, and serves MTHI/MTLO/MFHI/MFLO. It drives a stall request to the hazard unit while an operation is in flight.

---
 rtl/execute_mdu_if.sv | 36 +++
 rtl/execute_mdu.sv | 195 +++++++++++++++++++
 tb/tb_execute_mdu.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_mdu_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_mdu_if
// Purpose  : Request/response bundle between the EXECUTE stage and the MDU.
// Revision : 1.0 - initial release
// ============================================================================
interface execute_mdu_if #(
  parameter int NB        = 32,
  parameter int NB_MDU_OP = 3
);
  logic                 i_valid;
  logic [NB_MDU_OP-1:0] i_mdu_op;
  logic [NB-1:0]        i_data_a;
  logic [NB-1:0]        i_data_b;
  logic                 o_ready;
  logic                 o_stall;
  logic                 o_done;
  logic                 o_div_by_zero;
  logic                 o_illegal_op;
  logic [NB-1:0]        o_hi;
  logic [NB-1:0]        o_lo;
  logic [NB-1:0]        o_mf_result;

  modport master (
    output i_valid, i_mdu_op, i_data_a, i_data_b,
    input  o_ready, o_stall, o_done, o_div_by_zero, o_illegal_op,
           o_hi, o_lo, o_mf_result
  );

  modport slave (
    input  i_valid, i_mdu_op, i_data_a, i_data_b,
    output o_ready, o_stall, o_done, o_div_by_zero, o_illegal_op,
           o_hi, o_lo, o_mf_result
  );
endinterface
`default_nettype wire

// File: rtl/execute_mdu.sv
`default_nettype none
// ============================================================================
// Module   : execute_mdu
// Purpose  : Radix-2 iterative MULT/DIV unit holding HI/LO, with MT/MF moves.
//            Define MDU_DIV_EN to build the restoring divider (DIV/DIVU).
// Revision : 1.0 - initial release
// ============================================================================
module execute_mdu #(
  parameter int NB        = 32,
  parameter int NB_MDU_OP = 3,
  parameter int NB_CNT    = $clog2(NB) + 1
) (
  input wire            i_clk,
  input wire            i_reset,
  execute_mdu_if.slave  bus
);

  localparam logic [NB_MDU_OP-1:0] c_OP_MFLO  = NB_MDU_OP'(0);
  localparam logic [NB_MDU_OP-1:0] c_OP_MULT  = NB_MDU_OP'(1);
  localparam logic [NB_MDU_OP-1:0] c_OP_MULTU = NB_MDU_OP'(2);
  localparam logic [NB_MDU_OP-1:0] c_OP_DIV   = NB_MDU_OP'(3);
  localparam logic [NB_MDU_OP-1:0] c_OP_DIVU  = NB_MDU_OP'(4);
  localparam logic [NB_MDU_OP-1:0] c_OP_MTHI  = NB_MDU_OP'(5);
  localparam logic [NB_MDU_OP-1:0] c_OP_MTLO  = NB_MDU_OP'(6);
  localparam logic [NB_MDU_OP-1:0] c_OP_MFHI  = NB_MDU_OP'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [NB-1:0]     r_hi, r_lo;
  logic [2*NB-1:0]   r_p;      // {upper, lower}: product, or {remainder, quotient}
  logic [NB-1:0]     r_opnd;   // multiplicand or divisor magnitude
  logic [NB_CNT-1:0] r_cnt;
  logic              r_neg_res;
  logic              r_done;
  logic              w_ready, w_stall, w_start;

  wire w_idle   = (r_state == S_IDLE);
  wire w_take   = bus.i_valid & w_idle;
  wire w_op_mul = (bus.i_mdu_op == c_OP_MULT) | (bus.i_mdu_op == c_OP_MULTU);
  wire w_op_div = (bus.i_mdu_op == c_OP_DIV)  | (bus.i_mdu_op == c_OP_DIVU);
  wire w_op_sgn = (bus.i_mdu_op == c_OP_MULT) | (bus.i_mdu_op == c_OP_DIV);

  wire [NB-1:0] w_abs_a = (w_op_sgn && bus.i_data_a[NB-1]) ? -bus.i_data_a : bus.i_data_a;
  wire [NB-1:0] w_abs_b = (w_op_sgn && bus.i_data_b[NB-1]) ? -bus.i_data_b : bus.i_data_b;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set.
  wire [NB:0]     w_mul_sum  = {1'b0, r_p[2*NB-1:NB]} + {1'b0, (r_p[0] ? r_opnd : {NB{1'b0}})};
  wire [2*NB-1:0] w_mul_next = {w_mul_sum, r_p[NB-1:1]};
  wire [2*NB-1:0] w_prod_fix = r_neg_res ? -r_p : r_p;

`ifdef MDU_DIV_EN
  logic          r_is_div, r_neg_rem, r_dz, r_dz_pulse;
  logic [NB-1:0] r_a_raw;

  // Restoring step: shift in next dividend bit, keep the difference if no borrow.
  wire [NB:0]     w_rem_sh   = r_p[2*NB-1:NB-1];
  wire [NB:0]     w_diff     = w_rem_sh - {1'b0, r_opnd};
  wire [2*NB-1:0] w_div_next = w_diff[NB] ? {w_rem_sh[NB-1:0], r_p[NB-2:0], 1'b0}
                                          : {w_diff[NB-1:0],   r_p[NB-2:0], 1'b1};
  wire [NB-1:0]   w_quo_fix  = r_neg_res ? -r_p[NB-1:0]    : r_p[NB-1:0];
  wire [NB-1:0]   w_rem_fix  = r_neg_rem ? -r_p[2*NB-1:NB] : r_p[2*NB-1:NB];

  assign w_start           = w_take & (w_op_mul | w_op_div);
  assign bus.o_div_by_zero = r_dz_pulse;
  assign bus.o_illegal_op  = 1'b0;
`else
  logic r_illegal;

  assign w_start           = w_take & w_op_mul;
  assign bus.o_div_by_zero = 1'b0;
  assign bus.o_illegal_op  = r_illegal;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_start) w_state_next = S_CALC;
      end
      S_CALC: begin
        w_stall = bus.i_valid;
        if (r_cnt == NB_CNT'(1)) w_state_next = S_FIX;
      end
      S_FIX: begin
        w_stall      = bus.i_valid;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_p        <= '0;
      r_opnd     <= '0;
      r_cnt      <= '0;
      r_neg_res  <= 1'b0;
      r_done     <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div   <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
      r_dz_pulse <= 1'b0;
      r_a_raw    <= '0;
`else
      r_illegal  <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
`ifdef MDU_DIV_EN
      r_dz_pulse <= 1'b0;
`else
      r_illegal  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_p       <= {{NB{1'b0}}, (w_op_mul ? w_abs_b : w_abs_a)};
            r_opnd    <= w_op_mul ? w_abs_a : w_abs_b;
            r_cnt     <= NB_CNT'(NB);
            r_neg_res <= w_op_sgn & (bus.i_data_a[NB-1] ^ bus.i_data_b[NB-1]);
`ifdef MDU_DIV_EN
            r_is_div  <= w_op_div;
            r_neg_rem <= w_op_sgn & bus.i_data_a[NB-1];
            r_dz      <= (bus.i_data_b == '0);
            r_a_raw   <= bus.i_data_a;
`endif
          end
          if (w_take && (bus.i_mdu_op == c_OP_MTHI)) r_hi <= bus.i_data_a;
          if (w_take && (bus.i_mdu_op == c_OP_MTLO)) r_lo <= bus.i_data_a;
`ifndef MDU_DIV_EN
          if (w_take && w_op_div) r_illegal <= 1'b1;
`endif
        end
        S_CALC: begin
          r_cnt <= r_cnt - 1'b1;
`ifdef MDU_DIV_EN
          r_p   <= r_is_div ? w_div_next : w_mul_next;
`else
          r_p   <= w_mul_next;
`endif
        end
        S_FIX: begin
          r_done <= 1'b1;
`ifdef MDU_DIV_EN
          if (r_is_div) begin
            r_dz_pulse <= r_dz;
            if (r_dz) begin
              r_lo <= '1;
              r_hi <= r_a_raw;
            end else begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end
          end else
`endif
          begin
            r_hi <= w_prod_fix[2*NB-1:NB];
            r_lo <= w_prod_fix[NB-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_mf_result = '0;
    if (w_take && (bus.i_mdu_op == c_OP_MFHI)) bus.o_mf_result = r_hi;
    if (w_take && (bus.i_mdu_op == c_OP_MFLO)) bus.o_mf_result = r_lo;
  end

  assign bus.o_ready = w_ready;
  assign bus.o_stall = w_stall;
  assign bus.o_done  = r_done;
  assign bus.o_hi    = r_hi;
  assign bus.o_lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_execute_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_mdu
// Purpose  : Randomised scoreboard bench for execute_mdu (NB=32); the divide
//            expectations follow MDU_DIV_EN as the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_mdu;
  localparam int NB = 32;
  localparam logic [2:0] OP_MFLO = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_MFHI = 3'd7;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;

  execute_mdu_if #(.NB(NB), .NB_MDU_OP(3)) bus ();
  execute_mdu #(.NB(NB), .NB_MDU_OP(3)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          illegal;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
    int          issue_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  always @(posedge i_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Architectural result of an arithmetic op, straight from integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    int              ia, ib;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op == OP_MULT) begin
      sa = $signed(a); sb = $signed(b); sp = sa * sb;
      hi = sp[63:32]; lo = sp[31:0];
    end else if (op == OP_MULTU) begin
      ua = {32'd0, a}; ub = {32'd0, b}; up = ua * ub;
      hi = up[63:32]; lo = up[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
    end else if (op == OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000; hi = 32'd0;
      end else begin
        ia = $signed(a); ib = $signed(b);
        lo = 32'(ia / ib); hi = 32'(ia % ib);
      end
    end else begin
      lo = a / b; hi = a % b;
    end
  endtask

  task automatic expect_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   is_mul = (op == OP_MULT) || (op == OP_MULTU);
    bit   is_div = (op == OP_DIV)  || (op == OP_DIVU);
    e.issue_cyc = cyc;
    if (is_mul || (is_div && DIV_EN)) begin
      model(op, a, b, e.hi, e.lo, e.dz);
      e.illegal = 1'b0;
      m_hi = e.hi;
      m_lo = e.lo;
      exp_q.push_back(e);
    end else if (is_div) begin
      e.illegal = 1'b1; e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0;
      exp_q.push_back(e);
    end else if (op == OP_MTHI) begin
      m_hi = a;
    end else if (op == OP_MTLO) begin
      m_lo = a;
    end
  endtask

  // Entered and left on a falling edge; waits for the unit to return idle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int g;
    bit busy = (op == OP_MULT) || (op == OP_MULTU) ||
               (DIV_EN && ((op == OP_DIV) || (op == OP_DIVU)));
    check("ready_before_issue", 32'(bus.o_ready), 32'd1);
    bus.i_valid  = 1'b1;
    bus.i_mdu_op = op;
    bus.i_data_a = a;
    bus.i_data_b = b;
    #1;
    if (op == OP_MFHI)      check("mfhi", bus.o_mf_result, m_hi);
    else if (op == OP_MFLO) check("mflo", bus.o_mf_result, m_lo);
    else                    check("mf_zero_other_op", bus.o_mf_result, 32'd0);
    expect_op(op, a, b);
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid  = 1'b0;
    bus.i_mdu_op = 3'($urandom_range(0, 7));
    bus.i_data_a = $urandom;
    bus.i_data_b = $urandom;
    if (busy) begin
      g = 0;
      while (!bus.o_ready && g < NB + 10) begin
        @(negedge i_clk);
        g++;
      end
      if (!bus.o_ready) begin
        n_checks++; n_fail++;
        $display("FAIL ready_timeout actual=0 expected=1 after %0d cycles", g);
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every o_done / o_illegal_op pulse retires the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (bus.o_done || bus.o_illegal_op) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result done=%0b illegal=%0b expected no pulse",
                   bus.o_done, bus.o_illegal_op);
        end else begin
          mon_e = exp_q.pop_front();
          check("illegal_flag", 32'(bus.o_illegal_op), 32'(mon_e.illegal));
          check("done_flag", 32'(bus.o_done), 32'(!mon_e.illegal));
          check("hi", bus.o_hi, mon_e.hi);
          check("lo", bus.o_lo, mon_e.lo);
          check("div_by_zero", 32'(bus.o_div_by_zero), 32'(mon_e.dz));
          check("latency", 32'(cyc - mon_e.issue_cyc), mon_e.illegal ? 32'd1 : 32'(NB + 2));
        end
      end else if (bus.o_div_by_zero) begin
        n_checks++; n_fail++;
        $display("FAIL div_by_zero_without_done actual=1 expected=0");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt;
    int g;
    logic [2:0] op;
    bus.i_valid  = 1'b0;
    bus.i_mdu_op = OP_MFLO;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    #1;
    check("rst_hi", bus.o_hi, 32'd0);
    check("rst_lo", bus.o_lo, 32'd0);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_stall", 32'(bus.o_stall), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_dz", 32'(bus.o_div_by_zero), 32'd0);
    check("rst_illegal", 32'(bus.o_illegal_op), 32'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);

    issue(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIVU,  32'h0000_0007, 32'h0000_0000);
    issue(OP_MFHI,  32'd0, 32'd0);
    issue(OP_MTHI,  32'hCAFE_0001, 32'd0);
    issue(OP_MFHI,  32'd0, 32'd0);

    // MTLO, then MULTU 5x6 with MFLO held valid while the unit is busy.
    issue(OP_MTLO, 32'h0000_1234, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0);
    bus.i_valid  = 1'b1;
    bus.i_mdu_op = OP_MULTU;
    bus.i_data_a = 32'd5;
    bus.i_data_b = 32'd6;
    expect_op(OP_MULTU, 32'd5, 32'd6);
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_mdu_op = OP_MFLO;
    bus.i_data_a = $urandom;
    bus.i_data_b = $urandom;
    stall_cnt = 0;
    g = 0;
    while (!bus.o_done && g < NB + 10) begin
      if (bus.o_stall) stall_cnt++;
      @(negedge i_clk);
      g++;
    end
    check("stall_cycles", 32'(stall_cnt), 32'(NB + 1));
    check("done_seen", 32'(bus.o_done), 32'd1);
    check("mflo_on_done_cycle", bus.o_mf_result, 32'h0000_001E);
    check("stall_low_on_done", 32'(bus.o_stall), 32'd0);
    bus.i_valid = 1'b0;
    @(negedge i_clk);

    // Abort a MULT partway through CALC with reset.
    bus.i_valid  = 1'b1;
    bus.i_mdu_op = OP_MULT;
    bus.i_data_a = $urandom;
    bus.i_data_b = $urandom;
    expect_op(OP_MULT, bus.i_data_a, bus.i_data_b);
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    check("stall_mid_calc", 32'(bus.o_ready), 32'd0);
    #2;
    i_reset = 1'b1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    check("abort_hi", bus.o_hi, 32'd0);
    check("abort_lo", bus.o_lo, 32'd0);
    check("abort_ready", 32'(bus.o_ready), 32'd1);
    check("abort_done", 32'(bus.o_done), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (NB + 5) @(negedge i_clk);
    issue(OP_MFLO, 32'd0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, pick(), pick());
    end
    issue(OP_MFHI, 32'd0, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0);

    repeat (4) @(negedge i_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
